// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants for the branch predictor
//
// Purpose: counter encodings, reset/allocate counter values, default table
// geometry and the index-width helper used by the predictor and its counter.
// Ports: none (package).
package bp_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Value after reset and value written when a taken branch allocates
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  function automatic int bp_idxw(input int entries);
    return $clog2(entries);
  endfunction

  // Default geometry; PC[1:0] is never part of index or tag
  localparam int BP_ENTRIES = 16;
  localparam int IDXW       = bp_idxw(BP_ENTRIES);
  localparam int TAGW       = 30 - IDXW;

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - 2-bit saturating up/down counter update
//
// Purpose: next value of a direction counter given the resolved outcome.
// Ports:
//   ctr_i    current counter value
//   taken_i  resolved direction (1 = count up, 0 = count down)
//   ctr_o    updated counter, saturating at CTR_ST and CTR_SNT
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB branch predictor and next-PC select
//
// Purpose: supplies the next fetch PC every cycle. Fetch looks up a direct-mapped
// BTB with 2-bit counters; Execute trains it, detects mispredictions and
// overrides the fetch prediction with the redirect PC.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   PCF, PCPlus4F           fetch PC and its sequential successor
//   NextPCF                 PC to load into the fetch PC register
//   PredTakenF, PredTargetF prediction for PCF, carried down the pipe
//   BranchE, TakenE, PCE, PCPlus4E, PCTargetE
//                           resolved branch information from Execute
//   PredTakenE, PredTargetE prediction that travelled with the Execute instruction
//   MispredictE             redirect/flush request
//   BranchCount, MissCount  saturating performance counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  output logic [31:0] NextPCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] PCTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int IW = (ENTRIES == BP_ENTRIES) ? IDXW : bp_idxw(ENTRIES);
  localparam int TW = (ENTRIES == BP_ENTRIES) ? TAGW : 30 - IW;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Word-aligned PCs: the low two bits never select anything
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup
  logic [IW-1:0] idx_f;
  logic [TW-1:0] tag_f;
  logic          hit_f;

  assign idx_f       = PCF[IW+1:2];
  assign tag_f       = PCF[31:IW+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCPlus4F;

  // Execute-side resolution
  logic [IW-1:0] idx_e;
  logic [TW-1:0] tag_e;
  logic          tag_match_e;
  logic          hit_e;
  logic [31:0]   redirect_pc;
  logic [1:0]    ctr_upd;

  assign idx_e       = PCE[IW+1:2];
  assign tag_e       = PCE[31:IW+2];
  assign tag_match_e = (tag_q[idx_e] == tag_e);
  assign hit_e       = valid_q[idx_e] && tag_match_e;

  always_comb begin
    MispredictE = 1'b0;
    redirect_pc = PCPlus4E;
    if (BranchE) begin
      MispredictE = (TakenE != PredTakenE) || (TakenE && (PCTargetE != PredTargetE));
      redirect_pc = TakenE ? PCTargetE : PCPlus4E;
    end else if (PredTakenE) begin
      // A non-branch was predicted taken: the entry is stale, fall through
      MispredictE = 1'b1;
    end
  end

  assign NextPCF = MispredictE ? redirect_pc : PredTargetF;

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[idx_e]),
    .taken_i (TakenE),
    .ctr_o   (ctr_upd)
  );

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (BranchE && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (MispredictE && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (BranchE) begin
        if (hit_e) begin
          ctr_q[idx_e] <= ctr_upd;
          if (TakenE) target_q[idx_e] <= PCTargetE;
        end else if (TakenE) begin
          // Allocation evicts whatever aliased into this slot
          valid_q[idx_e]  <= 1'b1;
          tag_q[idx_e]    <= tag_e;
          target_q[idx_e] <= PCTargetE;
          ctr_q[idx_e]    <= CTR_ALLOC;
        end
      end else if (PredTakenE && tag_match_e) begin
        valid_q[idx_e] <= 1'b0;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCPlus4F, NextPCF, PredTargetF;
  logic        PredTakenF;
  logic        BranchE, TakenE, PredTakenE, MispredictE;
  logic [31:0] PCE, PCPlus4E, PCTargetE, PredTargetE;
  logic [31:0] BranchCount, MissCount;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .NextPCF     (NextPCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .BranchE     (BranchE),
    .TakenE      (TakenE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .PCTargetE   (PCTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
    .BranchCount (BranchCount),
    .MissCount   (MissCount)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one record per BTB slot, 16 slots
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_bcnt, m_mcnt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, input logic [31:0] pc4,
                                   output bit tk, output logic [31:0] tg);
    int i;
    i  = m_idx(pc);
    tk = m_valid[i] && (m_tag[i] == pc / 64) && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : pc4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic set_fetch(input logic [31:0] pc);
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
  endtask

  // Execute inputs; the carried prediction is what the model predicts for pce now
  task automatic set_exec(input bit br, input bit tk, input logic [31:0] pce,
                          input logic [31:0] tgt);
    bit          ptk;
    logic [31:0] ptg;
    m_lookup(pce, pce + 32'd4, ptk, ptg);
    BranchE     = br;
    TakenE      = tk;
    PCE         = pce;
    PCPlus4E    = pce + 32'd4;
    PCTargetE   = tgt;
    PredTakenE  = ptk;
    PredTargetE = ptg;
  endtask

  // Check all outputs against the model, then clock and advance the model
  task automatic step();
    bit          ftk, misp;
    logic [31:0] ftg, redir, nxt;
    int          i;
    #1;
    m_lookup(PCF, PCPlus4F, ftk, ftg);
    if (BranchE) begin
      misp  = (TakenE != PredTakenE) || (TakenE && PCTargetE != PredTargetE);
      redir = TakenE ? PCTargetE : PCPlus4E;
    end else begin
      misp  = PredTakenE;
      redir = PCPlus4E;
    end
    nxt = misp ? redir : ftg;
    chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, ftk});
    chk("PredTargetF", PredTargetF, ftg);
    chk("MispredictE", {31'd0, MispredictE}, {31'd0, misp});
    chk("NextPCF", NextPCF, nxt);
    chk("BranchCount", BranchCount, m_bcnt[31:0]);
    chk("MissCount", MissCount, m_mcnt[31:0]);
    @(posedge clk);
    i = m_idx(PCE);
    if (BranchE) begin
      if (m_valid[i] && m_tag[i] == PCE / 64) begin
        m_ctr[i] = TakenE ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                          : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (TakenE) m_tgt[i] = PCTargetE;
      end else if (TakenE) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = PCE / 64;
        m_tgt[i]   = PCTargetE;
        m_ctr[i]   = 2;
      end
    end else if (PredTakenE && m_tag[i] == PCE / 64) begin
      m_valid[i] = 1'b0;
    end
    if (BranchE && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
    if (misp && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    rst = 1'b0;
    set_fetch(32'h40);
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    #3;
    chk("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
    chk("rst_NextPCF", NextPCF, 32'h44);
    chk("rst_BranchCount", BranchCount, 32'd0);
    chk("rst_MissCount", MissCount, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_NextPCF", NextPCF, 32'h44);
    step();

    // Cold taken branch allocates with ctr=2
    set_exec(1'b1, 1'b1, 32'h40, 32'h100);
    #1;
    chk("cold_misp", {31'd0, MispredictE}, 32'd1);
    chk("cold_next", NextPCF, 32'h100);
    step();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("cold_pred", {31'd0, PredTakenF}, 32'd1);
    chk("cold_tgt", PredTargetF, 32'h100);
    step();

    // Saturation: three more taken (3,3,3), then two not-taken (2,1)
    for (int k = 0; k < 3; k++) begin
      set_exec(1'b1, 1'b1, 32'h40, 32'h100);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      set_exec(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      chk("sat_pred_before", {31'd0, PredTakenF}, 32'd1);
      step();
    end
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sat_pred_after", {31'd0, PredTakenF}, 32'd0);
    step();

    // Back to ctr=3, then the target moves
    for (int k = 0; k < 2; k++) begin
      set_exec(1'b1, 1'b1, 32'h40, 32'h100);
      step();
    end
    set_exec(1'b1, 1'b1, 32'h40, 32'h200);
    #1;
    chk("tgt_misp", {31'd0, MispredictE}, 32'd1);
    chk("tgt_next", NextPCF, 32'h200);
    step();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("tgt_new", PredTargetF, 32'h200);
    step();

    // Alias eviction by 0x80, then stale-entry invalidation
    set_exec(1'b1, 1'b1, 32'h80, 32'h300);
    step();
    set_fetch(32'h40);
    set_exec(1'b0, 1'b0, 32'h80, 32'h0);
    #1;
    chk("alias_evicted", {31'd0, PredTakenF}, 32'd0);
    chk("stale_predtk", {31'd0, PredTakenE}, 32'd1);
    chk("stale_misp", {31'd0, MispredictE}, 32'd1);
    chk("stale_next", NextPCF, 32'h84);
    step();
    set_fetch(32'h80);
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("stale_cleared", {31'd0, PredTakenF}, 32'd0);
    step();

    // Same-cycle lookup and training on index 0 sees old contents
    set_fetch(32'h40);
    set_exec(1'b1, 1'b1, 32'h40, 32'h500);
    step();
    set_exec(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("rw_old", {31'd0, PredTakenF}, 32'd1);
    step();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rw_new", {31'd0, PredTakenF}, 32'd0);
    step();

    // Asynchronous reset mid-cycle after retraining
    set_exec(1'b1, 1'b1, 32'h40, 32'h600);
    step();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("pre_arst_pred", {31'd0, PredTakenF}, 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_pred", {31'd0, PredTakenF}, 32'd0);
    chk("arst_next", NextPCF, 32'h44);
    chk("arst_bcnt", BranchCount, 32'd0);
    chk("arst_mcnt", MissCount, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomized traffic over a small aliasing PC set
    for (int n = 0; n < 400; n++) begin
      set_fetch(rnd_pc());
      set_exec($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rnd_pc(),
               32'h1000 + (32'($urandom_range(0, 3)) << 2));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. It sits directly upstream of the fetch stage and replaces the fetch stage's 2-input PC-select mux: every cycle it supplies the next fetch PC. It looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters in fetch and trains on branches resolved in execute. It also detects mispredictions and produces the redirect PC, plus the flush request the hazard unit uses for Decode and Execute.

## Interface
- ENTRIES, 16, BTB entry count; power of 2, at least 2.
- IDXW, log2(ENTRIES), index width; derived, not overridden.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset; asserted at 0.
- PCF  input  32  current fetch PC.
- PCPlus4F  input  32  PCF+4 from the fetch adder.
- NextPCF  output  32  PC to load into the fetch PC register.
- PredTakenF  output  1  prediction for PCF; pipelined downstream alongside the instruction.
- PredTargetF  output  32  predicted target for PCF; pipelined downstream.
- BranchE  input  1  the instruction in Execute is a branch or jump (0 for bubbles).
- TakenE  input  1  resolved direction.
- PCE  input  32  PC of the instruction in Execute.
- PCPlus4E  input  32  PCE+4.
- PCTargetE  input  32  resolved target.
- PredTakenE  input  1  PredTakenF carried to Execute.
- PredTargetE  input  32  PredTargetF carried to Execute.
- MispredictE  output  1  redirect request; hazard unit flushes Decode and Execute.
- BranchCount  output  32  resolved branches since reset.
- MissCount  output  32  mispredictions since reset.

## Operation
- Entry fields: valid, tag = PC[31:IDXW+2], target[31:0], ctr[1:0]. Index = PC[IDXW+1:2].
- **Lookup** (combinational on PCF):
  - hit = valid && tag match.
  - PredTakenF = hit && ctr[1].
  - PredTargetF = PredTakenF ? target : PCPlus4F.
- **Mispredict**:
  - If BranchE: MispredictE = (TakenE != PredTakenE) || (TakenE && PCTargetE != PredTargetE).
  - If !BranchE && PredTakenE (stale entry): MispredictE = 1.
  - Otherwise MispredictE = 0.
- **Redirect PC**: TakenE ? PCTargetE : PCPlus4E when BranchE; PCPlus4E for the stale case.
- **NextPCF** = MispredictE ? redirect PC : PredTargetF. Execute has priority over the fetch prediction.
- **Training** on the clock edge when BranchE, at PCE's index:
  - Hit: ctr increments when taken (saturates at 3) and decrements when not taken (saturates at 0). target is written with PCTargetE when taken.
  - Miss, taken: allocate the entry with valid=1, tag, target=PCTargetE, ctr=2, overwriting the previous occupant.
  - Miss, not taken: no write.
- **Stale entry** (!BranchE && PredTakenE): clear valid at PCE's index, only if the tag matches PCE.
- **Counters**: BranchCount increments on BranchE. MissCount increments on MispredictE. Both saturate at 0xFFFF_FFFF.
- **Reset**: all valid bits = 0, ctr = 1, tags and targets = 0, both perf counters = 0. Reset is asynchronous and may assert mid-training; the state seen after reset is the reset state only.
- **Stalls**: StallF does not affect the predictor. Lookups remain combinational, and the fetch PC register holds off the load.

## Timing
- Lookup: 0 cycles, so PredTakenF, PredTargetF and NextPCF are valid in the same cycle as PCF.
- Mispredict/redirect: 0 cycles from the Execute inputs.
- Training write lands at the next rising edge. A lookup of the same index in the update cycle sees the old contents, and sees the new contents from the following cycle.
- Simultaneous training and lookup on different indices are independent.
- Outputs during reset: NextPCF = PCPlus4F, PredTakenF = 0, MispredictE = 0 when PredTakenE = 0, counters = 0.

## Structure
- Shared package `bp_pkg`:
  - counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - reset counter value WNT and allocate value WT.
  - derived widths IDXW and TAGW = 30-IDXW.
- One sub-module, `bp_sat_ctr`: 2-bit saturating up/down update function/module, instantiated per entry or shared at the update port.
- Tables are flops with asynchronous reset, not inferred RAM.

## Test plan
- **Reset**: release rst, PCF=0x40, PCPlus4F=0x44 -> PredTakenF=0, NextPCF=0x44, BranchCount=MissCount=0.
- **Cold taken branch**: BranchE=1, TakenE=1, PCE=0x40, PCTargetE=0x100, PredTakenE=0 -> MispredictE=1, NextPCF=0x100. Next cycle, PCF=0x40 -> PredTakenF=1, PredTargetF=0x100.
- **Saturation**: four taken then two not-taken resolutions at 0x40 -> ctr sequence 2,3,3,3,2,1. Prediction is taken until the last update, then not taken.
- **Target change**: hit at 0x40 with ctr=3, TakenE=1, PCTargetE=0x200, PredTargetE=0x100 -> MispredictE=1, NextPCF=0x200, entry target becomes 0x200.
- **Alias eviction and stale entry**: with ENTRIES=16, taken branch at 0x80 evicts 0x40 (same index 0). Then !BranchE, PredTakenE=1, PCE=0x80 -> MispredictE=1, NextPCF=PCPlus4E=0x84, entry invalidated.
- **Same-cycle read/write and async reset**: lookup index 0 while training index 0 -> old prediction. Assert rst mid-sequence -> all predictions revert to not-taken immediately, counters read 0.
